mux_n_scan: RTL and testbench
=============================

Name: mux_n_scan

Overview:
Parametrised, registered N-to-1 multiplexer. It is the clocked successor to the combinational 4-input mux.
- Manual mode: selects one W-bit channel by index.
- Scan mode: steps through all channels automatically, holding each for a programmable dwell time.
- Sits between a bank of sampled inputs and a single shared downstream consumer, such as a display driver or serial logger.

Parameters:
N, 4, number of input channels (N >= 2; need not be a power of 2)
W, 1, width of each channel in bits
DW, 8, width of the dwell-count input
SW, $clog2(N), select/channel index width (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
n_reset  input  1  synchronous active-low reset
din  input  N*W  packed channel data; channel k = din[k*W +: W]
sel  input  SW  channel index used in manual mode
mode  input  1  0 = manual select, 1 = auto-scan
dwell  input  DW  scan mode: enabled cycles per channel minus one
en  input  1  clock enable; when low, all state frozen
y  output  W  registered selected channel data
ch  output  SW  index of channel currently presented on y
valid  output  1  y/ch hold a legal, freshly sampled value
wrap  output  1  one-cycle pulse when scan wraps from channel N-1 to 0

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-low on n_reset.
- All outputs are registered.

Reset:
- While n_reset = 0 at a rising edge: y = 0, ch = 0, valid = 0, wrap = 0, dwell counter = 0, FSM = MANUAL.
- Reset asserted mid-scan aborts the scan immediately. No partial dwell is carried over.

FSM states: MANUAL, SCAN. The state is held only to detect mode edges.
- MANUAL -> SCAN when mode = 1 and en = 1.
- SCAN -> MANUAL when mode = 0 and en = 1.

Manual mode (mode = 0, en = 1):
- Latency is 1 cycle: y <= din[sel*W +: W], ch <= sel, valid <= 1.
- Out-of-range sel (sel >= N, possible only when N is not a power of 2): y <= 0, ch <= sel, valid <= 0.
- wrap is always 0 in manual mode.

Scan mode (mode = 1, en = 1):
- On the cycle entering SCAN from MANUAL: ch <= 0, dwell counter <= 0, y <= din[0 +: W], valid <= 1.
- Otherwise, each enabled cycle y <= din[ch_next*W +: W]. Data is resampled every cycle, not only on channel change.
- Dwell counter increments each enabled cycle.
- When counter == dwell: the counter clears and ch advances by 1.
- Channel N-1 advances to 0. wrap = 1 on exactly the cycle ch becomes 0 by advancing. The initial entry to channel 0 does not assert wrap.
- dwell = 0: ch advances every enabled cycle. Each channel is held dwell+1 enabled cycles.
- A dwell change mid-scan takes effect at the next comparison. If counter > new dwell, the channel advances on the next enabled cycle.
- sel is ignored in scan mode. valid = 1 throughout.

Enable:
- When en = 0, y, ch, counter and FSM hold; valid <= 0; wrap <= 0.
- When en returns to 1, operation resumes from the held counter and channel.

Simultaneous events:
- Reset has priority over en and mode.
- A mode change and a would-be channel advance on the same cycle: the mode change wins.
- Returning to MANUAL presents sel on the next edge.

Test Plan:
1. N=4, W=1, mode=0, din=4'b0100, sel=0..3, one per cycle -> one cycle after each sel, y = 0,0,1,0, ch = sel, valid = 1, wrap = 0.
2. N=4, W=1, din=4'b1010, mode=1, dwell=2 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. y follows din bits. wrap = 1 only on the cycle ch returns to 0 after 3.
3. Scan with dwell=0, N=4 -> ch = 0,1,2,3,0,1,... every cycle. wrap pulses every 4th cycle.
4. Mid-scan, ch=2 with counter=1: drop en for 3 cycles -> y/ch frozen at ch 2, valid = 0. Re-assert en -> ch 2 held for 1 more cycle (dwell=2), then 3.
5. Mid-scan, assert n_reset=0 for 1 cycle -> next edge: y=0, ch=0, valid=0, wrap=0. Release with mode=1 -> scan restarts at ch 0 without a wrap pulse.
6. N=3, W=8, mode=0, sel=3 -> y=8'h00, valid=0. Then sel=2 with din channel 2 = 8'hA5 -> y=8'hA5, valid=1 one cycle later.

Source files
------------

// File: rtl/mux_n_scan.sv
// ---------------------------------------------------------------------------
// mux_n_scan
//   Registered N-to-1 multiplexer with two modes:
//     manual : presents the channel selected by sel one cycle later
//     scan   : steps through channels 0..N-1 automatically, holding each for
//              dwell+1 enabled cycles, and pulses wrap on the N-1 -> 0 step
//
// Ports
//   clk      system clock, all state updates on the rising edge
//   n_reset  synchronous active-low reset
//   din      packed channel data, channel k = din[k*W +: W]
//   sel      channel index used in manual mode
//   mode     0 = manual select, 1 = auto-scan
//   dwell    scan mode: enabled cycles per channel minus one
//   en       clock enable, when low all state is frozen
//   y        registered selected channel data
//   ch       index of the channel currently presented on y
//   valid    y/ch hold a legal, freshly sampled value
//   wrap     one-cycle pulse when the scan wraps from channel N-1 to 0
// ---------------------------------------------------------------------------
module mux_n_scan #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 1,
    parameter int unsigned DW = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [N*W-1:0]  din,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic [DW-1:0]   dwell,
    input  logic            en,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   ch,
    output logic            valid,
    output logic            wrap
);

    // The FSM only remembers which mode was active last enabled cycle, so
    // the MANUAL -> SCAN edge can be told apart from an ongoing scan.
    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);
    localparam logic [SW-1:0] FIRST_CH = '0;

    state_t         state_q;
    state_t         state_d;
    logic [DW-1:0]  cnt_q;
    logic [DW-1:0]  cnt_d;
    logic [W-1:0]   y_d;
    logic [SW-1:0]  ch_d;
    logic           valid_d;
    logic           wrap_d;

    // Extract channel idx from the packed input bus; idx must be < N.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] data,
                                          input logic [SW-1:0]  idx);
        logic [N*W-1:0] shifted;
        shifted = data >> (32'(idx) * W);
        return shifted[W-1:0];
    endfunction

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            y       <= '0;
            ch      <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y       <= y_d;
            ch      <= ch_d;
            valid   <= valid_d;
            wrap    <= wrap_d;
        end
    end

    // Next-state: mode is only sampled on enabled cycles.
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = mode ? SCAN : MANUAL;
        end
    end

    // Next output / datapath values.
    always_comb begin
        // Frozen by default: data, channel and counter hold, flags drop.
        y_d     = y;
        ch_d    = ch;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (en) begin
            if (!mode) begin
                // Manual select; out-of-range indices present zero, invalid.
                ch_d  = sel;
                cnt_d = '0;
                if (32'(sel) < N) begin
                    y_d     = pick(din, sel);
                    valid_d = 1'b1;
                end else begin
                    y_d     = '0;
                    valid_d = 1'b0;
                end
            end else if (state_q == MANUAL) begin
                // First scan cycle always starts cleanly at channel 0.
                ch_d    = FIRST_CH;
                cnt_d   = '0;
                y_d     = pick(din, FIRST_CH);
                valid_d = 1'b1;
            end else begin
                // '>=' so a dwell lowered below the running count advances
                // on the next enabled cycle instead of waiting for rollover.
                if (cnt_q >= dwell) begin
                    cnt_d = '0;
                    if (ch >= LAST_CH) begin
                        ch_d   = FIRST_CH;
                        wrap_d = 1'b1;
                    end else begin
                        ch_d = ch + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
                // Data is resampled every cycle, not only on channel change.
                y_d     = pick(din, ch_d);
                valid_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_scan.sv
// ---------------------------------------------------------------------------
// tb_mux_n_scan
//   Drives two instances (N=4/W=1 and N=3/W=8) with shared control inputs.
//   A driver computes the expected response from a behavioural model and
//   queues it; a monitor pops and compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_mux_n_scan;

    logic        clk;
    logic        n_reset;
    logic        mode;
    logic        en;
    logic [7:0]  dwell;

    logic [3:0]  din_a;
    logic [1:0]  sel_a;
    logic [0:0]  y_a;
    logic [1:0]  ch_a;
    logic        valid_a;
    logic        wrap_a;

    logic [23:0] din_b;
    logic [1:0]  sel_b;
    logic [7:0]  y_b;
    logic [1:0]  ch_b;
    logic        valid_b;
    logic        wrap_b;

    mux_n_scan #(.N(4), .W(1), .DW(8)) dut_a (
        .clk(clk), .n_reset(n_reset), .din(din_a), .sel(sel_a), .mode(mode),
        .dwell(dwell), .en(en), .y(y_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a)
    );

    mux_n_scan #(.N(3), .W(8), .DW(8)) dut_b (
        .clk(clk), .n_reset(n_reset), .din(din_b), .sel(sel_b), .mode(mode),
        .dwell(dwell), .en(en), .y(y_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b)
    );

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] ch;
        logic       valid;
        logic       wrap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    // Model state per instance (0 = N4/W1, 1 = N3/W8).
    bit         m_scan [2];
    int         m_ch   [2];
    int         m_held [2];   // enabled cycles the current channel has been shown
    logic [7:0] m_y    [2];
    bit         m_valid[2];
    bit         m_wrap [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] chan_val(input logic [31:0] d, input int k, input int w);
        logic [31:0] t;
        t = d >> (k * w);
        return (w == 8) ? t[7:0] : {7'b0, t[0]};
    endfunction

    // One clock of the reference behaviour, stated in terms of the observable
    // rules: each scan channel is shown dwell+1 enabled cycles, then moves on.
    task automatic model_step(input int i, input bit r, input bit e, input bit m,
                              input int dw, input int s, input logic [31:0] d);
        int n;
        int w;
        n = (i == 0) ? 4 : 3;
        w = (i == 0) ? 1 : 8;
        if (!r) begin
            m_scan[i] = 0; m_ch[i] = 0; m_held[i] = 0;
            m_y[i] = 8'h00; m_valid[i] = 0; m_wrap[i] = 0;
        end else if (!e) begin
            m_valid[i] = 0; m_wrap[i] = 0;
        end else if (!m) begin
            m_scan[i] = 0;
            m_ch[i]   = s;
            m_wrap[i] = 0;
            m_valid[i] = (s < n);
            m_y[i]    = (s < n) ? chan_val(d, s, w) : 8'h00;
        end else if (!m_scan[i]) begin
            m_scan[i] = 1; m_ch[i] = 0; m_held[i] = 1;
            m_y[i] = chan_val(d, 0, w); m_valid[i] = 1; m_wrap[i] = 0;
        end else begin
            if (m_held[i] > dw) begin
                m_ch[i]   = (m_ch[i] + 1) % n;
                m_wrap[i] = (m_ch[i] == 0);
                m_held[i] = 1;
            end else begin
                m_held[i] = m_held[i] + 1;
                m_wrap[i] = 0;
            end
            m_y[i] = chan_val(d, m_ch[i], w);
            m_valid[i] = 1;
        end
    endtask

    // Drive one cycle of stimulus and queue what both DUTs must show after it.
    task automatic apply(input bit r, input bit e, input bit m, input logic [7:0] dw,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [3:0] da, input logic [23:0] db);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        n_reset = r; en = e; mode = m; dwell = dw;
        sel_a = sa; sel_b = sb; din_a = da; din_b = db;
        model_step(0, r, e, m, int'(dw), int'(sa), 32'(da));
        model_step(1, r, e, m, int'(dw), int'(sb), 32'(db));
        ea = '{y: m_y[0], ch: 2'(m_ch[0]), valid: m_valid[0], wrap: m_wrap[0]};
        eb = '{y: m_y[1], ch: 2'(m_ch[1]), valid: m_valid[1], wrap: m_wrap[1]};
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    // Monitor: compare each queued expectation just after the edge it covers.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                tests++;
                if ({8'(y_a), ch_a, valid_a, wrap_a} !== {e.y, e.ch, e.valid, e.wrap}) begin
                    failed++;
                    $display("FAIL dut_a cycle %0d: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                             cycle, y_a, ch_a, valid_a, wrap_a, e.y, e.ch, e.valid, e.wrap);
                end
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                tests++;
                if ({y_b, ch_b, valid_b, wrap_b} !== {e.y, e.ch, e.valid, e.wrap}) begin
                    failed++;
                    $display("FAIL dut_b cycle %0d: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                             cycle, y_b, ch_b, valid_b, wrap_b, e.y, e.ch, e.valid, e.wrap);
                end
            end
        end
    end

    initial begin
        bit         r_mode;
        logic [7:0] r_dwell;
        n_reset = 1'b0; en = 1'b0; mode = 1'b0; dwell = 8'd0;
        sel_a = '0; sel_b = '0; din_a = '0; din_b = '0;

        // Reset state.
        repeat (2) apply(1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 2'd0, 4'h0, 24'h0);

        // Manual select on both instances, including sel out of range for N=3.
        for (int s = 0; s < 4; s++)
            apply(1'b1, 1'b1, 1'b0, 8'd0, 2'(s), 2'(s), 4'b0100, 24'hA5_3C_11);
        apply(1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 2'd3, 4'b0100, 24'hA5_3C_11);
        apply(1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 2'd2, 4'b0100, 24'hA5_3C_11);

        // Scan with dwell=2 over a full wrap.
        repeat (14) apply(1'b1, 1'b1, 1'b1, 8'd2, 2'd1, 2'd1, 4'b1010, 24'hC3_5A_96);

        // Re-enter scan with dwell=0: one channel per cycle.
        apply(1'b1, 1'b1, 1'b0, 8'd0, 2'd3, 2'd1, 4'b1010, 24'hC3_5A_96);
        repeat (10) apply(1'b1, 1'b1, 1'b1, 8'd0, 2'd3, 2'd1, 4'b0110, 24'h12_34_56);

        // Freeze mid-scan at channel 2 with one cycle left, then resume.
        apply(1'b1, 1'b1, 1'b0, 8'd2, 2'd0, 2'd0, 4'b1100, 24'h0F_F0_AA);
        repeat (8) apply(1'b1, 1'b1, 1'b1, 8'd2, 2'd0, 2'd0, 4'b1100, 24'h0F_F0_AA);
        repeat (3) apply(1'b1, 1'b0, 1'b1, 8'd2, 2'd0, 2'd0, 4'b0011, 24'h77_66_55);
        repeat (4) apply(1'b1, 1'b1, 1'b1, 8'd2, 2'd0, 2'd0, 4'b1100, 24'h0F_F0_AA);

        // Reset mid-scan, then restart the scan without a wrap pulse.
        apply(1'b0, 1'b1, 1'b1, 8'd1, 2'd0, 2'd0, 4'b1111, 24'hFF_FF_FF);
        repeat (6) apply(1'b1, 1'b1, 1'b1, 8'd1, 2'd0, 2'd0, 4'b1001, 24'h81_42_24);

        // Lower dwell below the running count mid-scan.
        repeat (3) apply(1'b1, 1'b1, 1'b1, 8'd5, 2'd0, 2'd0, 4'b0101, 24'h01_02_03);
        repeat (3) apply(1'b1, 1'b1, 1'b1, 8'd0, 2'd0, 2'd0, 4'b0101, 24'h01_02_03);

        // Randomized traffic.
        r_mode  = 1'b0;
        r_dwell = 8'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 39) == 0)
                r_dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20))
                                                      : 8'($urandom_range(0, 3));
            apply($urandom_range(0, 99) != 0,
                  $urandom_range(0, 99) < 85,
                  r_mode, r_dwell,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  4'($urandom), 24'($urandom));
        end

        repeat (2) @(negedge clk);
        tests++;
        if (q_a.size() + q_b.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expectations, want 0", q_a.size() + q_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
